// File: rtl/vga_pkg.sv
// vga_pkg: default 640x480@60 segment constants, derived totals and coordinate width
package vga_pkg;
  localparam int COORD_W = 10;
  localparam int DEF_H_DISPLAY = 640;
  localparam int DEF_H_FRONT = 16;
  localparam int DEF_H_SYNC = 96;
  localparam int DEF_H_BACK = 48;
  localparam int DEF_V_DISPLAY = 480;
  localparam int DEF_V_FRONT = 10;
  localparam int DEF_V_SYNC = 2;
  localparam int DEF_V_BACK = 33;
  function automatic int seg_total(input int a, input int b, input int c, input int d);
    return a + b + c + d;
  endfunction
  localparam int H_TOTAL = seg_total(DEF_H_DISPLAY, DEF_H_FRONT, DEF_H_SYNC, DEF_H_BACK);
  localparam int V_TOTAL = seg_total(DEF_V_DISPLAY, DEF_V_FRONT, DEF_V_SYNC, DEF_V_BACK);
endpackage

// File: rtl/vga_sync_tick_gen.sv
// tick_gen: one-clock pixel enable every CLK_DIV clocks (constant 1 when CLK_DIV is 1)
module tick_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);
  localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] LAST = DW'(CLK_DIV - 1);
  logic [DW-1:0] div_cnt_q, div_cnt_d;
  assign tick = div_cnt_q == LAST;
  always_comb div_cnt_d = tick ? '0 : div_cnt_q + DW'(1);
  always_ff @(posedge clk) begin
    if (reset) div_cnt_q <= '0;
    else div_cnt_q <= div_cnt_d;
  end
endmodule

// File: rtl/vga_sync.sv
// vga_sync: VGA scan counters with registered sync/blank/frame-start decode.
// Define VGA_SYNC_DELAY_EN to delay hsync/vsync/video_on by one pixel tick.
module vga_sync import vga_pkg::*; #(
  parameter int CLK_DIV = 4,
  parameter int H_DISPLAY = DEF_H_DISPLAY,
  parameter int H_FRONT = DEF_H_FRONT,
  parameter int H_SYNC = DEF_H_SYNC,
  parameter int H_BACK = DEF_H_BACK,
  parameter int V_DISPLAY = DEF_V_DISPLAY,
  parameter int V_FRONT = DEF_V_FRONT,
  parameter int V_SYNC = DEF_V_SYNC,
  parameter int V_BACK = DEF_V_BACK
) (
  input  logic               clk,
  input  logic               reset,
  output logic               p_tick,
  output logic [COORD_W-1:0] pix_x,
  output logic [COORD_W-1:0] pix_y,
  output logic               hsync,
  output logic               vsync,
  output logic               video_on,
  output logic               frame_start
);
  localparam int H_TOT = seg_total(H_DISPLAY, H_FRONT, H_SYNC, H_BACK);
  localparam int V_TOT = seg_total(V_DISPLAY, V_FRONT, V_SYNC, V_BACK);
  if (H_TOT > (1 << COORD_W) || V_TOT > (1 << COORD_W) || CLK_DIV < 1) begin : g_bad_cfg
    $error("vga_sync: totals must fit in %0d-bit coordinates and CLK_DIV must be >= 1", COORD_W);
  end
  localparam logic [COORD_W-1:0] X_LAST = COORD_W'(H_TOT - 1);
  localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(V_TOT - 1);
  localparam logic [COORD_W-1:0] X_VIS = COORD_W'(H_DISPLAY);
  localparam logic [COORD_W-1:0] Y_VIS = COORD_W'(V_DISPLAY);
  localparam logic [COORD_W-1:0] HS_LO = COORD_W'(H_DISPLAY + H_FRONT);
  localparam logic [COORD_W-1:0] HS_HI = COORD_W'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [COORD_W-1:0] VS_LO = COORD_W'(V_DISPLAY + V_FRONT);
  localparam logic [COORD_W-1:0] VS_HI = COORD_W'(V_DISPLAY + V_FRONT + V_SYNC - 1);
  localparam logic [COORD_W-1:0] ONE = COORD_W'(1);
  logic [COORD_W-1:0] pix_x_q, pix_x_d, pix_y_q, pix_y_d;
  logic hs_q, hs_d, vs_q, vs_d, von_q, von_d, fs_q, fs_d, x_wrap;
  tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (.clk(clk), .reset(reset), .tick(p_tick));
  // decode from next-state counters so flags land on the same edge as the coordinates
  always_comb begin
    x_wrap = p_tick && pix_x_q == X_LAST;
    pix_x_d = p_tick ? (x_wrap ? '0 : pix_x_q + ONE) : pix_x_q;
    pix_y_d = x_wrap ? (pix_y_q == Y_LAST ? '0 : pix_y_q + ONE) : pix_y_q;
    hs_d = !(pix_x_d >= HS_LO && pix_x_d <= HS_HI);
    vs_d = !(pix_y_d >= VS_LO && pix_y_d <= VS_HI);
    von_d = pix_x_d < X_VIS && pix_y_d < Y_VIS;
    fs_d = x_wrap && pix_y_q == Y_LAST;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      pix_x_q <= '0;
      pix_y_q <= '0;
      hs_q <= 1'b1;
      vs_q <= 1'b1;
      von_q <= 1'b0;
      fs_q <= 1'b0;
    end else begin
      pix_x_q <= pix_x_d;
      pix_y_q <= pix_y_d;
      hs_q <= hs_d;
      vs_q <= vs_d;
      von_q <= von_d;
      fs_q <= fs_d;
    end
  end
  assign pix_x = pix_x_q;
  assign pix_y = pix_y_q;
  assign frame_start = fs_q;
`ifdef VGA_SYNC_DELAY_EN
  logic hs_dly_q, hs_dly_d, vs_dly_q, vs_dly_d, von_dly_q, von_dly_d;
  always_comb begin
    hs_dly_d = p_tick ? hs_q : hs_dly_q;
    vs_dly_d = p_tick ? vs_q : vs_dly_q;
    von_dly_d = p_tick ? von_q : von_dly_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      hs_dly_q <= 1'b1;
      vs_dly_q <= 1'b1;
      von_dly_q <= 1'b0;
    end else begin
      hs_dly_q <= hs_dly_d;
      vs_dly_q <= vs_dly_d;
      von_dly_q <= von_dly_d;
    end
  end
  assign hsync = hs_dly_q;
  assign vsync = vs_dly_q;
  assign video_on = von_dly_q;
`else
  assign hsync = hs_q;
  assign vsync = vs_q;
  assign video_on = von_q;
`endif
endmodule
